// File: rtl/prio_scan_encoder.sv
// -----------------------------------------------------------------------------
// prio_scan_encoder
//
// Accepts a request vector and emits the indices of its set bits one at a
// time, in priority order, under a valid/ready handshake. MSB_FIRST selects
// whether the highest (1) or lowest (0) set bit is emitted first.
//
// Optional feature: define PRIO_SCAN_ONEHOT_EN to add the out_onehot port
// (one-hot form of out_idx while out_valid is high, zero otherwise).
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   request vector offered
//   in_vec     in   [WIDTH-1:0] request vector
//   in_ready   out  block can accept a vector (IDLE and no flush)
//   flush      in   synchronous abort of the current scan
//   out_valid  out  out_idx holds a valid index
//   out_idx    out  [IDX_W-1:0] current winning bit index (0 when idle)
//   out_last   out  current index is the final pending bit
//   out_ready  in   consumer accepts out_idx
//   pend_cnt   out  [CNT_W-1:0] number of bits still pending
//   out_onehot out  [WIDTH-1:0] one-hot of out_idx (PRIO_SCAN_ONEHOT_EN only)
//   zero_err   out  one-cycle pulse after an all-zero vector is accepted
// -----------------------------------------------------------------------------
module prio_scan_encoder #(
  parameter  int WIDTH     = 8,
  parameter  int MSB_FIRST = 1,
  localparam int IDX_W     = $clog2(WIDTH),
  localparam int CNT_W     = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_vec,
  output logic             in_ready,
  input  logic             flush,
  output logic             out_valid,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_last,
  input  logic             out_ready,
  output logic [CNT_W-1:0] pend_cnt,
`ifdef PRIO_SCAN_ONEHOT_EN
  output logic [WIDTH-1:0] out_onehot,
`endif
  output logic             zero_err
);

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  state_t           state_r;
  logic [WIDTH-1:0] pend_r;
  logic             zero_err_r;

  logic [IDX_W-1:0] win_idx_s;
  logic [WIDTH-1:0] win_mask_s;
  logic [CNT_W-1:0] cnt_s;
  logic             last_s;
  logic             accept_s;
  logic             handshake_s;

  // Winning bit index. The loop visits bits in reverse priority order so the
  // last set bit visited (the highest-priority one) is the one kept.
  function automatic logic [IDX_W-1:0] pick_winner(input logic [WIDTH-1:0] v);
    logic [IDX_W-1:0] idx;
    int               j;
    idx = {IDX_W{1'b0}};
    for (int i = 0; i < WIDTH; i++) begin
      j   = (MSB_FIRST != 0) ? i : (WIDTH - 1 - i);
      idx = v[j] ? j[IDX_W-1:0] : idx;
    end
    return idx;
  endfunction

  // Number of set bits in v.
  function automatic logic [CNT_W-1:0] popcount(input logic [WIDTH-1:0] v);
    logic [CNT_W-1:0] cnt;
    cnt = {CNT_W{1'b0}};
    for (int i = 0; i < WIDTH; i++) begin
      cnt = cnt + {{(CNT_W-1){1'b0}}, v[i]};
    end
    return cnt;
  endfunction

  // Derived control and output decode from the registered state.
  always_comb begin
    win_idx_s   = pick_winner(pend_r);
    win_mask_s  = {{(WIDTH-1){1'b0}}, 1'b1} << win_idx_s;
    cnt_s       = popcount(pend_r);
    last_s      = (cnt_s == {{(CNT_W-1){1'b0}}, 1'b1});
    // A flush in IDLE blocks acceptance for that cycle.
    accept_s    = (state_r == IDLE) && in_valid && !flush;
    handshake_s = (state_r == SCAN) && out_ready;

    in_ready    = (state_r == IDLE) && !flush;
    out_valid   = (state_r == SCAN);
    out_idx     = out_valid ? win_idx_s : {IDX_W{1'b0}};
    out_last    = out_valid && last_s;
    pend_cnt    = cnt_s;
    zero_err    = zero_err_r;
`ifdef PRIO_SCAN_ONEHOT_EN
    out_onehot  = out_valid ? win_mask_s : {WIDTH{1'b0}};
`endif
  end

  // FSM, pending-bit register and zero-vector error pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      pend_r     <= {WIDTH{1'b0}};
      zero_err_r <= 1'b0;
    end else begin
      zero_err_r <= accept_s && (in_vec == {WIDTH{1'b0}});
      case (state_r)
        IDLE: begin
          if (accept_s && (in_vec != {WIDTH{1'b0}})) begin
            pend_r  <= in_vec;
            state_r <= SCAN;
          end else begin
            pend_r  <= {WIDTH{1'b0}};
            state_r <= IDLE;
          end
        end
        SCAN: begin
          // Flush wins over a simultaneous handshake; in_valid is ignored here.
          if (flush) begin
            pend_r  <= {WIDTH{1'b0}};
            state_r <= IDLE;
          end else if (handshake_s) begin
            pend_r  <= pend_r & ~win_mask_s;
            state_r <= last_s ? IDLE : SCAN;
          end else begin
            pend_r  <= pend_r;
            state_r <= SCAN;
          end
        end
        default: begin
          pend_r  <= {WIDTH{1'b0}};
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_prio_scan_encoder.sv
module tb_prio_scan_encoder;

  localparam int W = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_vec = 8'h00;
  logic       flush = 1'b0;
  logic       out_ready = 1'b0;

  logic       in_ready_m, out_valid_m, out_last_m, zero_err_m;
  logic [2:0] out_idx_m;
  logic [3:0] pend_cnt_m;
  logic       in_ready_l, out_valid_l, out_last_l, zero_err_l;
  logic [2:0] out_idx_l;
  logic [3:0] pend_cnt_l;
`ifdef PRIO_SCAN_ONEHOT_EN
  logic [7:0] out_onehot_m, out_onehot_l;
`endif

  int errors = 0;
  int checks = 0;

  // reference model state
  bit m_scan = 1'b0;
  bit m_zerr = 1'b0;
  int qm[$];
  int ql[$];

  always #5 clk = ~clk;

  prio_scan_encoder #(.WIDTH(W), .MSB_FIRST(1)) dut_m (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_vec(in_vec),
    .in_ready(in_ready_m), .flush(flush), .out_valid(out_valid_m),
    .out_idx(out_idx_m), .out_last(out_last_m), .out_ready(out_ready),
    .pend_cnt(pend_cnt_m),
`ifdef PRIO_SCAN_ONEHOT_EN
    .out_onehot(out_onehot_m),
`endif
    .zero_err(zero_err_m)
  );

  prio_scan_encoder #(.WIDTH(W), .MSB_FIRST(0)) dut_l (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_vec(in_vec),
    .in_ready(in_ready_l), .flush(flush), .out_valid(out_valid_l),
    .out_idx(out_idx_l), .out_last(out_last_l), .out_ready(out_ready),
    .pend_cnt(pend_cnt_l),
`ifdef PRIO_SCAN_ONEHOT_EN
    .out_onehot(out_onehot_l),
`endif
    .zero_err(zero_err_l)
  );

  typedef struct {
    logic       v;
    logic [7:0] vec;
    logic       fl;
    logic       rdy;
    logic       e_valid;
    logic       e_ready;
    logic [2:0] e_idx_m;
    logic [2:0] e_idx_l;
    logic [3:0] e_cnt;
    logic       e_last;
    logic       e_zerr;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic apply(input logic v, input logic [7:0] vec, input logic fl, input logic rdy);
    @(negedge clk);
    in_valid  = v;
    in_vec    = vec;
    flush     = fl;
    out_ready = rdy;
    #1;
  endtask

  // Compare both DUTs against the queue model for the current cycle.
  task automatic model_check();
    int em, el;
    em = m_scan ? qm[0] : 0;
    el = m_scan ? ql[0] : 0;
    chk("valid_m", {63'd0, out_valid_m}, {63'd0, m_scan});
    chk("valid_l", {63'd0, out_valid_l}, {63'd0, m_scan});
    chk("in_ready", {63'd0, in_ready_m & in_ready_l & (in_ready_m == in_ready_l)},
        {63'd0, (!m_scan && !flush)});
    chk("idx_m", {61'd0, out_idx_m}, 64'(em));
    chk("idx_l", {61'd0, out_idx_l}, 64'(el));
    chk("cnt", {56'd0, pend_cnt_m, pend_cnt_l}, {56'd0, 4'(qm.size()), 4'(ql.size())});
    chk("last", {62'd0, out_last_m, out_last_l},
        {62'd0, (m_scan && qm.size() == 1), (m_scan && ql.size() == 1)});
    chk("zero_err", {62'd0, zero_err_m, zero_err_l}, {62'd0, m_zerr, m_zerr});
`ifdef PRIO_SCAN_ONEHOT_EN
    chk("onehot", {48'd0, out_onehot_m, out_onehot_l},
        {48'd0, (m_scan ? (8'd1 << em) : 8'd0), (m_scan ? (8'd1 << el) : 8'd0)});
`endif
  endtask

  // Advance one clock and update the model from the inputs driven this cycle.
  task automatic tick();
    @(posedge clk);
    m_zerr = !m_scan && !flush && in_valid && (in_vec == 8'h00);
    if (m_scan) begin
      if (flush) begin
        qm.delete(); ql.delete(); m_scan = 1'b0;
      end else if (out_ready) begin
        void'(qm.pop_front()); void'(ql.pop_front());
        if (qm.size() == 0) m_scan = 1'b0;
      end
    end else if (!flush && in_valid && in_vec != 8'h00) begin
      for (int i = W - 1; i >= 0; i--) if (in_vec[i]) qm.push_back(i);
      for (int i = 0; i < W; i++) if (in_vec[i]) ql.push_back(i);
      m_scan = 1'b1;
    end
  endtask

  task automatic reset_pulse();
    in_valid = 1'b0; in_vec = 8'h00; flush = 1'b0; out_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst_valid", {63'd0, out_valid_m | out_valid_l}, 64'd0);
    chk("rst_idx", {58'd0, out_idx_m, out_idx_l}, 64'd0);
    chk("rst_cnt", {56'd0, pend_cnt_m, pend_cnt_l}, 64'd0);
    chk("rst_last_zerr", {60'd0, out_last_m, out_last_l, zero_err_m, zero_err_l}, 64'd0);
    qm.delete(); ql.delete(); m_scan = 1'b0; m_zerr = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int  hs, prev_idx;
    bit  stalled, done;

    // vectors: msb-first / lsb-first scan of A5, zero accept, flush in idle
    tbl[0] = '{1'b1, 8'hA5, 1'b0, 1'b1, 1'b0, 1'b1, 3'd0, 3'd0, 4'd0, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 3'd7, 3'd0, 4'd4, 1'b0, 1'b0};
    tbl[2] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 3'd5, 3'd2, 4'd3, 1'b0, 1'b0};
    tbl[3] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 3'd2, 3'd5, 4'd2, 1'b0, 1'b0};
    tbl[4] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 3'd7, 4'd1, 1'b1, 1'b0};
    tbl[5] = '{1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 3'd0, 3'd0, 4'd0, 1'b0, 1'b0};
    tbl[6] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 3'd0, 3'd0, 4'd0, 1'b0, 1'b1};
    tbl[7] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 3'd0, 3'd0, 4'd0, 1'b0, 1'b0};
    tbl[8] = '{1'b1, 8'h03, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 3'd0, 4'd0, 1'b0, 1'b0};
    tbl[9] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 3'd0, 3'd0, 4'd0, 1'b0, 1'b0};

    // power-on reset
    @(posedge clk);
    reset_pulse();

    // table-driven vectors
    for (int k = 0; k < 10; k++) begin
      apply(tbl[k].v, tbl[k].vec, tbl[k].fl, tbl[k].rdy);
      model_check();
      chk($sformatf("t%0d_valid", k), {62'd0, out_valid_m, out_valid_l}, {62'd0, tbl[k].e_valid, tbl[k].e_valid});
      chk($sformatf("t%0d_ready", k), {62'd0, in_ready_m, in_ready_l}, {62'd0, tbl[k].e_ready, tbl[k].e_ready});
      chk($sformatf("t%0d_idx", k), {58'd0, out_idx_m, out_idx_l}, {58'd0, tbl[k].e_idx_m, tbl[k].e_idx_l});
      chk($sformatf("t%0d_cnt", k), {56'd0, pend_cnt_m, pend_cnt_l}, {56'd0, tbl[k].e_cnt, tbl[k].e_cnt});
      chk($sformatf("t%0d_last", k), {62'd0, out_last_m, out_last_l}, {62'd0, tbl[k].e_last, tbl[k].e_last});
      chk($sformatf("t%0d_zerr", k), {62'd0, zero_err_m, zero_err_l}, {62'd0, tbl[k].e_zerr, tbl[k].e_zerr});
      tick();
    end

    // FF with out_ready toggling; 0F offered mid-scan must be ignored
    apply(1'b1, 8'hFF, 1'b0, 1'b0);
    model_check();
    tick();
    hs = 0; stalled = 1'b0; prev_idx = 0; done = 1'b0;
    for (int k = 0; k < 40 && !done; k++) begin
      apply((k == 3), (k == 3) ? 8'h0F : 8'h00, 1'b0, (k % 2 == 1));
      model_check();
      if (!out_valid_m) begin
        done = 1'b1;
      end else begin
        if (stalled) chk("stall_hold_idx", {61'd0, out_idx_m}, 64'(prev_idx));
        if (out_ready) hs++;
        stalled  = !out_ready;
        prev_idx = out_idx_m;
      end
      tick();
    end
    chk("ff_handshakes", 64'(hs), 64'd8);
    chk("ff_done", {63'd0, done}, 64'd1);

    // flush on first output cycle overrides handshake
    apply(1'b1, 8'hC0, 1'b0, 1'b1); model_check(); tick();
    apply(1'b0, 8'h00, 1'b1, 1'b1); model_check();
    chk("flush_pre_cnt", {60'd0, pend_cnt_m}, 64'd2);
    tick();
    apply(1'b0, 8'h00, 1'b0, 1'b1); model_check();
    chk("flush_idle", {61'd0, out_valid_m, in_ready_m, pend_cnt_m == 4'd0}, 64'b011);
    tick();

    // reset mid-scan
    apply(1'b1, 8'hC0, 1'b0, 1'b1); model_check(); tick();
    apply(1'b0, 8'h00, 1'b0, 1'b0); model_check();
    reset_pulse();
    for (int k = 0; k < 3; k++) begin
      apply(1'b0, 8'h00, 1'b0, 1'b1); model_check();
      chk("post_rst_idle", {60'd0, out_valid_m, out_valid_l, pend_cnt_m == 4'd0, in_ready_m}, 64'b0011);
      tick();
    end

`ifdef PRIO_SCAN_ONEHOT_EN
    apply(1'b1, 8'h12, 1'b0, 1'b1); model_check(); tick();
    apply(1'b0, 8'h00, 1'b0, 1'b1);
    chk("onehot_0", {56'd0, out_onehot_m}, 64'h10); model_check(); tick();
    apply(1'b0, 8'h00, 1'b0, 1'b1);
    chk("onehot_1", {56'd0, out_onehot_m}, 64'h02); model_check(); tick();
    apply(1'b0, 8'h00, 1'b0, 1'b1);
    chk("onehot_2", {56'd0, out_onehot_m}, 64'h00); model_check(); tick();
`endif

    // randomized traffic against the queue model
    for (int k = 0; k < 400; k++) begin
      apply(1'($urandom_range(0, 1)),
            ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom),
            ($urandom_range(0, 9) == 0),
            ($urandom_range(0, 2) != 0));
      model_check();
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/prio_scan_encoder.md
PRIO_SCAN_ENCODER -- requirements
Module: prio_scan_encoder

Interface
REQ-001 SHALL have parameter WIDTH, default 8, number of request bits (legal range 2..64).
REQ-002 SHALL have parameter MSB_FIRST, default 1; 1 = highest set bit wins, 0 = lowest set bit wins.
REQ-003 SHALL derive localparam IDX_W = $clog2(WIDTH) and CNT_W = $clog2(WIDTH+1).
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 in_valid  input  1  request vector offered.
REQ-007 in_vec  input  WIDTH  request vector.
REQ-008 in_ready  output  1  block can accept a vector.
REQ-009 flush  input  1  synchronous abort of the current scan.
REQ-010 out_valid  output  1  out_idx holds a valid encoded index.
REQ-011 out_idx  output  IDX_W  index of the current winning bit.
REQ-012 out_last  output  1  current index is the final pending bit.
REQ-013 out_ready  input  1  consumer accepts out_idx.
REQ-014 pend_cnt  output  CNT_W  number of bits still pending.
REQ-015 zero_err  output  1  one-cycle pulse: all-zero vector accepted.

Function
REQ-016 SHALL implement a two-state FSM: IDLE and SCAN.
REQ-017 IDLE: in_ready=1, out_valid=0; an in_valid cycle is an accept.
REQ-018 An accept with in_vec!=0 SHALL latch in_vec into the pending register and enter SCAN at the next edge.
REQ-019 An accept with in_vec==0 SHALL assert zero_err for exactly the following cycle and remain in IDLE.
REQ-020 SCAN: in_ready=0, out_valid=1; out_idx = winning set bit of the pending register per MSB_FIRST.
REQ-021 Latency: out_valid SHALL be high the cycle after the accept edge.
REQ-022 A cycle with out_valid&out_ready is a handshake; the winning bit SHALL be cleared at that edge.
REQ-023 out_idx, out_last and pend_cnt SHALL stay stable while out_valid=1 and out_ready=0.
REQ-024 out_last SHALL be 1 when pend_cnt==1; a handshake with out_last=1 returns the FSM to IDLE.
REQ-025 pend_cnt SHALL equal the popcount of the pending register, 0 in IDLE.
REQ-026 flush=1 SHALL clear the pending register and force IDLE at the next edge; it overrides any handshake in the same cycle, and a flush in IDLE blocks acceptance that cycle (in_ready=0).
REQ-027 in_valid during SCAN SHALL be ignored; the vector is not captured.
REQ-028 out_idx SHALL read 0 whenever out_valid=0.

Reset
REQ-029 rst_n low SHALL force IDLE, pending=0, out_valid=0, out_idx=0, out_last=0, pend_cnt=0, zero_err=0, in_ready=1 (after release).
REQ-030 Reset mid-scan SHALL discard all pending bits; no index is emitted after release.

Configuration
REQ-031 Macro PRIO_SCAN_ONEHOT_EN defined: extra output port out_onehot [WIDTH-1:0] = one-hot of out_idx when out_valid=1, else all zeros.
REQ-032 Macro absent: port out_onehot and its logic SHALL not exist; all other behaviour identical.

Verification (WIDTH=8 unless noted)
REQ-033 MSB_FIRST=1, accept 8'b1010_0101, out_ready=1 -> out_idx 7,5,2,0 on consecutive cycles, out_last only on 0, then in_ready=1.
REQ-034 MSB_FIRST=0, same vector -> out_idx 0,2,5,7; pend_cnt 4,3,2,1.
REQ-035 Accept 8'h00 -> zero_err high exactly one cycle, out_valid stays 0, in_ready stays 1.
REQ-036 Accept 8'hFF, out_ready toggles 1/0 -> each index held stable while stalled; 8 handshakes total, in_vec=8'h0F offered mid-scan is not captured.
REQ-037 Accept 8'b1100_0000, flush with out_ready=1 on the first out cycle -> no bit cleared by handshake, IDLE next cycle, pend_cnt=0; rst_n pulse mid-scan gives the same result.
REQ-038 With PRIO_SCAN_ONEHOT_EN, accept 8'b0001_0010 -> out_onehot 8'b0001_0000 then 8'b0000_0010, then 8'h00.
